// File: rtl/miller_encoder.sv
// miller_encoder: serialises DATA_W-bit words MSB first as
// Miller, FM0 or Manchester half-bit line levels.
module miller_encoder #(
    parameter int HALF_BIT_CYCLES = 4,
    parameter int DATA_W          = 8
) (
    input  logic              clk_100m,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        mode_i,
    output logic              line_o,
    output logic              busy_o
);

    localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] HC_LAST = CW'(HALF_BIT_CYCLES - 1);
    localparam logic [BW-1:0] BC_TOP  = BW'(DATA_W - 1);

    localparam logic [1:0] M_FM0 = 2'b01;
    localparam logic [1:0] M_MAN = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [1:0]        mode_q, mode_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     half_cnt_q, half_cnt_d;
    logic              half_q, half_d;
    logic              line_q, line_d;
    logic              prev_bit_q, prev_bit_d;
    logic              last_cyc;
    logic              accept;
    logic [DATA_W-1:0] shifted;

    // Level of the first half of a bit, given the level at bit start.
    function automatic logic first_half(input logic [1:0] m,
                                        input logic b,
                                        input logic l,
                                        input logic p);
        if (m == M_MAN) begin
            return ~b;
        end else if (m == M_FM0) begin
            return ~l;
        end else begin
            return (b | p) ? l : ~l;
        end
    endfunction

    // Level of the second half of a bit, given the first-half level.
    function automatic logic second_half(input logic [1:0] m,
                                         input logic b,
                                         input logic f);
        if (m == M_MAN) begin
            return b;
        end else if (m == M_FM0) begin
            return b ? f : ~f;
        end else begin
            return b ? ~f : f;
        end
    endfunction

    assign last_cyc = (state_q == ST_SEND) && half_q &&
                      (half_cnt_q == HC_LAST) && (bit_cnt_q == '0);
    assign ready_o  = (state_q == ST_IDLE) || last_cyc;
    assign accept   = valid_i && ready_o;
    assign busy_o   = (state_q == ST_SEND);
    assign line_o   = line_q;
    assign shifted  = shreg_q << 1;

    // Next-state: accept words, step half-bits and bits, return to idle.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        mode_d     = mode_q;
        bit_cnt_d  = bit_cnt_q;
        half_cnt_d = half_cnt_q;
        half_d     = half_q;
        line_d     = line_q;
        prev_bit_d = prev_bit_q;
        if (accept) begin
            state_d    = ST_SEND;
            shreg_d    = data_i;
            mode_d     = mode_i;
            bit_cnt_d  = BC_TOP;
            half_cnt_d = '0;
            half_d     = 1'b0;
            line_d     = first_half(mode_i, data_i[DATA_W-1],
                                    line_q, prev_bit_q);
        end else if (state_q == ST_SEND) begin
            if (half_cnt_q != HC_LAST) begin
                half_cnt_d = half_cnt_q + CW'(1);
            end else begin
                half_cnt_d = '0;
                if (!half_q) begin
                    half_d = 1'b1;
                    line_d = second_half(mode_q, shreg_q[DATA_W-1], line_q);
                    if (mode_q != M_MAN && mode_q != M_FM0) begin
                        prev_bit_d = shreg_q[DATA_W-1];
                    end
                end else if (bit_cnt_q != '0) begin
                    half_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    shreg_d   = shifted;
                    line_d    = first_half(mode_q, shifted[DATA_W-1],
                                           line_q, prev_bit_q);
                end else begin
                    state_d    = ST_IDLE;
                    half_d     = 1'b0;
                    prev_bit_d = 1'b1;
                    if (mode_q == M_MAN) begin
                        line_d = 1'b0;
                    end
                end
            end
        end
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            mode_q     <= '0;
            bit_cnt_q  <= '0;
            half_cnt_q <= '0;
            half_q     <= 1'b0;
            line_q     <= 1'b0;
            prev_bit_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            mode_q     <= mode_d;
            bit_cnt_q  <= bit_cnt_d;
            half_cnt_q <= half_cnt_d;
            half_q     <= half_d;
            line_q     <= line_d;
            prev_bit_q <= prev_bit_d;
        end
    end

endmodule

// File: tb/tb_miller_encoder.sv
// tb_miller_encoder: directed vectors plus random words against
// a half-bit stream model of the three line codes.
module tb_miller_encoder;

    localparam int H = 2;
    localparam int W = 4;

    logic         clk_100m = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [1:0]   mode_i = '0;
    logic         line_o;
    logic         busy_o;

    int total = 0;
    int bad = 0;

    miller_encoder #(.HALF_BIT_CYCLES(H), .DATA_W(W)) dut (
        .clk_100m(clk_100m),
        .rst_n(rst_n),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .mode_i(mode_i),
        .line_o(line_o),
        .busy_o(busy_o)
    );

    always #5 clk_100m = ~clk_100m;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk_100m);
        chk("rst_line", line_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        @(negedge clk_100m);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] data;
        logic [7:0] hb;
        logic       idle_line;
    } vec_t;

    // Stream model: expected line level per upcoming cycle.
    bit m_q[$];
    bit m_L;
    bit m_prev;
    bit m_man;

    task automatic model_init();
        m_q.delete();
        m_L = 0;
        m_prev = 1;
        m_man = 0;
    endtask

    task automatic push_half(input bit v);
        for (int k = 0; k < H; k++) m_q.push_back(v);
    endtask

    task automatic model_word(input logic [1:0] m, input logic [W-1:0] d);
        bit b, f, s;
        m_man = (m == 2'b10);
        for (int i = W - 1; i >= 0; i--) begin
            b = d[i];
            if (m == 2'b10) begin
                f = ~b;
                s = b;
            end else if (m == 2'b01) begin
                f = ~m_L;
                s = b ? f : ~f;
            end else begin
                if (b) begin
                    f = m_L;
                    s = ~m_L;
                end else if (!m_prev) begin
                    f = ~m_L;
                    s = f;
                end else begin
                    f = m_L;
                    s = m_L;
                end
                m_prev = b;
            end
            push_half(f);
            push_half(s);
            m_L = s;
        end
    endtask

    // One cycle: compare at negedge, drive inputs, advance model.
    task automatic cyc(input logic v, input logic [W-1:0] d,
                       input logic [1:0] m);
        bit exp_rdy;
        bit was_busy;
        was_busy = (m_q.size() > 0);
        if (was_busy) begin
            exp_rdy = (m_q.size() == 1);
            chk("rnd_busy", busy_o, 1);
            chk("rnd_line", line_o, m_q[0]);
        end else begin
            exp_rdy = 1;
            chk("rnd_busy", busy_o, 0);
            chk("rnd_idle_line", line_o, m_L);
        end
        chk("rnd_ready", ready_o, exp_rdy);
        valid_i = v;
        data_i = d;
        mode_i = m;
        if (was_busy) void'(m_q.pop_front());
        if (v && exp_rdy) begin
            model_word(m, d);
        end else if (was_busy && m_q.size() == 0) begin
            m_prev = 1;
            if (m_man) m_L = 0;
        end
        @(negedge clk_100m);
    endtask

    vec_t vt[4];
    logic [15:0] b2b;

    initial begin
        vt[0] = '{2'b00, 4'b1011, 8'b01111001, 1'b1};
        vt[1] = '{2'b01, 4'b0110, 8'b10110010, 1'b0};
        vt[2] = '{2'b10, 4'b1000, 8'b01101010, 1'b0};
        vt[3] = '{2'b11, 4'b1011, 8'b01111001, 1'b1};

        @(negedge clk_100m);
        do_reset();

        // Single words in each mode, with a stray valid pulse mid-word.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            valid_i = 1'b1;
            data_i = vt[v].data;
            mode_i = vt[v].mode;
            @(negedge clk_100m);
            valid_i = 1'b0;
            for (int j = 0; j < 2 * H * W; j++) begin
                chk($sformatf("v%0d_line%0d", v, j), line_o,
                    vt[v].hb[7 - j / H]);
                chk($sformatf("v%0d_busy%0d", v, j), busy_o, 1);
                chk($sformatf("v%0d_rdy%0d", v, j), ready_o,
                    (j == 2 * H * W - 1));
                valid_i = (j == 5);
                data_i = 4'b1111;
                @(negedge clk_100m);
            end
            valid_i = 1'b0;
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("v%0d_idle_busy", v), busy_o, 0);
                chk($sformatf("v%0d_idle_line", v), line_o, vt[v].idle_line);
                @(negedge clk_100m);
            end
        end

        // Back-to-back Miller 0000, 0000 with valid held high.
        do_reset();
        b2b = 16'b0011001100110011;
        valid_i = 1'b1;
        data_i = 4'b0000;
        mode_i = 2'b00;
        @(negedge clk_100m);
        for (int j = 0; j < 4 * H * W; j++) begin
            chk($sformatf("b2b_line%0d", j), line_o, b2b[15 - j / H]);
            chk($sformatf("b2b_busy%0d", j), busy_o, 1);
            chk($sformatf("b2b_rdy%0d", j), ready_o,
                ((j % (2 * H * W)) == 2 * H * W - 1));
            if (j == 4 * H * W - 1) valid_i = 1'b0;
            @(negedge clk_100m);
        end
        chk("b2b_end_busy", busy_o, 0);
        chk("b2b_end_line", line_o, 1);

        // Reset in the second bit of a Miller word.
        do_reset();
        valid_i = 1'b1;
        data_i = 4'b0000;
        mode_i = 2'b00;
        @(negedge clk_100m);
        valid_i = 1'b0;
        repeat (3 * H) @(negedge clk_100m);
        chk("mid_line_pre", line_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_line", line_o, 0);
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_busy", busy_o, 0);
        @(negedge clk_100m);
        rst_n = 1'b1;
        @(negedge clk_100m);
        valid_i = 1'b1;
        @(negedge clk_100m);
        valid_i = 1'b0;
        for (int j = 0; j < 2 * H * W; j++) begin
            chk($sformatf("mid_line%0d", j), line_o, b2b[15 - j / H]);
            @(negedge clk_100m);
        end

        // Random words, modes and valid pattern against the model.
        do_reset();
        model_init();
        for (int c = 0; c < 1500; c++) begin
            cyc(($urandom % 4) != 0, W'($urandom), 2'($urandom));
        end
        for (int c = 0; c < 2 * H * W + 4; c++) begin
            cyc(1'b0, '0, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/miller_encoder.md
# miller_encoder

Parametrised line encoder and successor to the single-bit Miller coder. It accepts DATA_W-bit words over a valid/ready handshake and serialises them MSB first, one bit per 2×HALF_BIT_CYCLES clocks. Each word is encoded in one of three run-time-selected modes: Miller (delay), FM0 (bi-phase space) or Manchester. The block sits between the framing logic and the RF/line driver, and produces back-to-back bit streams with no gap when words are supplied in time.

## Interface
- HALF_BIT_CYCLES, 4, clocks per half-bit; legal range ≥1.
- DATA_W, 8, bits per input word; legal range ≥1.
- clk_100m  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_i  input  DATA_W  word to encode; bit DATA_W-1 is sent first.
- valid_i  input  1  data_i/mode_i are valid.
- ready_o  output  1  the block accepts the word this cycle.
- mode_i  input  2  00 Miller, 01 FM0, 10 Manchester, 11 reserved (encoded as Miller); sampled with the word.
- line_o  output  1  encoded line level, registered.
- busy_o  output  1  a word is being transmitted.

## Operation
- Accept occurs when valid_i & ready_o at a clock edge. data_i is loaded into a shift register, mode_i into a mode register, and a bit counter is set to DATA_W-1.
- Internal state:
  - L is the current line level, i.e. line_o.
  - prev_bit is the last Miller bit sent; it resets to 1.
  - A half-bit cycle counter runs 0..HALF_BIT_CYCLES-1.
  - A half flag selects first or second half.
  - The bit counter tracks position in the word.
- Per-bit encoding, with L being the level at the bit start:
  - Miller, b=1: first half L, second half ~L.
  - Miller, b=0 after prev_bit=0: first half ~L, second half unchanged.
  - Miller, b=0 after prev_bit=1: L, L.
  - FM0: first half ~L always. If b=0 the second half is the complement of the first half; if b=1 the second half equals the first half.
  - Manchester: b=1 gives 0 then 1; b=0 gives 1 then 0. This is independent of L.
- After each Miller bit, prev_bit takes that bit's value. prev_bit and L persist across back-to-back words.
- State machine:
  - IDLE: ready_o=1, busy_o=0. Line holds its last level in Miller/FM0; line is 0 if the last mode was Manchester. prev_bit is forced to 1 on entering IDLE.
  - SEND: busy_o=1. Steps half-bits, then bits. At the final cycle of the final half-bit of the last bit, ready_o=1. If a word is accepted there, stay in SEND with the new word and the new mode; otherwise go to IDLE.
- ready_o is 0 in all other SEND cycles. valid_i is ignored while ready_o=0.
- Reserved mode 11 is accepted and encoded exactly as Miller.
- Reset asserted mid-word: the word is discarded. line_o=0, ready_o=1, busy_o=0, prev_bit=1, state is IDLE, and all counters are 0.

## Timing
- Reset values: line_o=0, ready_o=1, busy_o=0.
- Accept at edge k: the first half-bit level of the MSB appears on line_o after edge k, i.e. it is valid from cycle k+1. busy_o rises in the same cycle.
- Each half-bit lasts exactly HALF_BIT_CYCLES cycles. A word lasts 2×HALF_BIT_CYCLES×DATA_W cycles.
- Back-to-back: accepting at the final cycle makes the next MSB half-bit follow immediately, with zero idle cycles.
- Without a new word, the edge after the final cycle enters IDLE: busy_o falls, and line_o either holds or goes to 0 (Manchester).
- HALF_BIT_CYCLES=1: line_o may change every cycle; ready_o is high only in the final cycle of each word.
- The counter width is $clog2(HALF_BIT_CYCLES) with a minimum of 1 bit, and wraps to 0 at HALF_BIT_CYCLES-1.

## Test plan
- **Miller.** Reset, then HALF_BIT_CYCLES=2, DATA_W=4, mode 00, word 4'b1011. Required: line_o half-bits 0,1,1,1,1,0,0,1, each 2 cycles. busy_o is high for 16 cycles, then IDLE with line_o held at 1.
- **FM0.** Mode 01, word 4'b0110, starting from L=0. Required: half-bits 1,0,1,1,0,0,1,0, ending with line_o=0.
- **Manchester.** Mode 10, word 4'b1000. Required: half-bits 0,1,1,0,1,0,1,0, then line_o=0 in IDLE.
- **Back-to-back.** Miller 4'b0000 then 4'b0000, with valid_i held high. Required:
  - ready_o pulses exactly once per word, in that word's last cycle.
  - With reset start L=0, prev_bit=1, the half-bits are 0,0,1,1,0,0,1,1 across word 1, continuing 0,0,1,1,0,0,1,1 in word 2.
  - busy_o never drops between the words.
- **Reserved mode and stalls.** Mode 11 with 4'b1011 gives output identical to test 1. valid_i pulsed while ready_o=0 is ignored, and no extra word is transmitted.
- **Reset mid-word.** Assert rst_n low during bit 2 of a Miller word. Required: line_o=0, ready_o=1, busy_o=0 immediately (asynchronous). After release, a Miller 4'b0000 word starts with half-bits 0,0, because prev_bit is 1.
